// File: rtl/hazard_scheduler.sv
// Purpose: stall/flush scheduler for an in-order 5-stage pipeline. It has no forwarding, so it
//          tracks in-flight register writers and can drain and hold the pipeline on request.
// Latency: all control outputs are combinational from the current inputs and state.
//          Counters, slots and halt_ack_o update on the rising clock edge.
// Backpressure: hold (drain/halt or a RAW hazard) freezes PC and IF/ID and bubbles ID/EX.
//               A MEM redirect overrides hold and flushes IF/ID, ID/EX and EX/MEM.
// Ports:
//   clk, reset (async, active-low)
//   id_*          : the ID-stage instruction (valid, sources, source-use flags, destination)
//   mem_redirect_i: taken control transfer in MEM
//   halt_req_i / halt_ack_o : drain-and-hold handshake
//   pc_write_o, if_id_write_o, *_flush_o : pipeline register controls
//   stall_count_o, flush_count_o : saturating performance counters
module hazard_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic             id_reg_write_i,
    input  logic [4:0]       id_dest_i,
    input  logic             mem_redirect_i,
    input  logic             halt_req_i,
    output logic             halt_ack_o,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t     state;
    logic       ex_vld, mem_vld, wb_vld;
    logic [4:0] ex_dest, mem_dest, wb_dest;

    logic rs_hit, rt_hit, data_hazard, hold, slots_empty;

    // Register $0 is hard-wired, so a writer to it never blocks a reader.
    function automatic logic slot_hit(input logic vld, input logic [4:0] dest,
                                      input logic [4:0] src);
        return vld && (dest != 5'd0) && (dest == src);
    endfunction

    assign rs_hit = slot_hit(ex_vld, ex_dest, id_rs_i) | slot_hit(mem_vld, mem_dest, id_rs_i)
                  | slot_hit(wb_vld, wb_dest, id_rs_i);
    assign rt_hit = slot_hit(ex_vld, ex_dest, id_rt_i) | slot_hit(mem_vld, mem_dest, id_rt_i)
                  | slot_hit(wb_vld, wb_dest, id_rt_i);

    // Without forwarding, a consumer waits until its producer has retired out of WB.
    assign data_hazard = id_valid_i && ((id_use_rs_i && rs_hit) || (id_use_rt_i && rt_hit));
    assign hold        = (state != RUN) || data_hazard;
    assign slots_empty = !ex_vld && !mem_vld && !wb_vld;

    // A redirect wins over hold: the fetch continues at the new target and everything younger
    // than MEM is squashed.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (mem_redirect_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (hold) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_flush_o  = 1'b1;
        end
    end

    // The drain FSM. halt_ack_o is assigned together with each state transition, so it stays
    // registered and equal to (state == HALTED).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            halt_ack_o <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req_i) state <= DRAIN;
                    halt_ack_o <= 1'b0;
                end
                DRAIN: begin
                    // Dropping the request takes priority over completing the drain.
                    if (!halt_req_i) begin
                        state      <= RUN;
                        halt_ack_o <= 1'b0;
                    end else if (slots_empty) begin
                        state      <= HALTED;
                        halt_ack_o <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_req_i) begin
                        state      <= RUN;
                        halt_ack_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    halt_ack_o <= 1'b0;
                end
            endcase
        end
    end

    // Writer tracking mirrors the pipeline registers: a held or squashed ID instruction
    // enters EX as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_vld   <= 1'b0;
            ex_dest  <= 5'd0;
            mem_vld  <= 1'b0;
            mem_dest <= 5'd0;
            wb_vld   <= 1'b0;
            wb_dest  <= 5'd0;
        end else begin
            wb_vld   <= mem_vld;
            wb_dest  <= mem_dest;
            mem_vld  <= ex_vld && !mem_redirect_i;
            mem_dest <= ex_dest;
            ex_vld   <= id_valid_i && id_reg_write_i && !mem_redirect_i && !hold;
            ex_dest  <= id_dest_i;
        end
    end

    // Stalls are counted only as hazard cycles in RUN. Drain/halt hold cycles and squashed
    // cycles are not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_o <= '0;
            flush_count_o <= '0;
        end else begin
            if (data_hazard && (state == RUN) && !mem_redirect_i && (stall_count_o != '1))
                stall_count_o <= stall_count_o + CNT_W'(1);
            if (mem_redirect_i && (flush_count_o != '1))
                flush_count_o <= flush_count_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of each performance counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port id_valid_i, input, 1, a real (non-bubble) instruction is present in ID.
REQ-005 SHALL have ports id_rs_i and id_rt_i, input, 5 each, the ID source register numbers.
REQ-006 SHALL have ports id_use_rs_i and id_use_rt_i, input, 1 each, the ID instruction reads rs/rt.
REQ-007 SHALL have port id_reg_write_i, input, 1, the ID instruction writes a register.
REQ-008 SHALL have port id_dest_i, input, 5, the final ID destination after RegDst/$ra selection.
REQ-009 SHALL have port mem_redirect_i, input, 1, a taken branch, jump or jr sits in MEM and the PC is being redirected.
REQ-010 SHALL have ports halt_req_i (input, 1, drain-and-hold request) and halt_ack_o (output, 1, pipeline empty and held).
REQ-011 SHALL have ports pc_write_o (PC load enable), if_id_write_o (IF/ID load enable), if_id_flush_o, id_ex_flush_o and ex_mem_flush_o (each forces a bubble into that register), all output, 1.
REQ-012 SHALL have ports stall_count_o and flush_count_o, output, CNT_W each, the performance counters.

Function
REQ-013 SHALL track in-flight writers in three registered slots EX, MEM and WB; each slot holds {valid, dest[4:0]}.
REQ-014 A slot SHALL match a source register when the slot is valid, its dest is nonzero, and dest equals that source; register $0 SHALL never create a hazard.
REQ-015 data_hazard SHALL be id_valid_i AND ((id_use_rs_i AND rs matches any slot) OR (id_use_rt_i AND rt matches any slot)); there is no forwarding, so a consumer waits until its producer has left WB.
REQ-016 The FSM SHALL have three states: RUN, DRAIN and HALTED; the reset state is RUN.
REQ-017 RUN SHALL go to DRAIN when halt_req_i=1.
REQ-018 DRAIN SHALL go to HALTED when all three slots are invalid.
REQ-019 DRAIN or HALTED SHALL return to RUN when halt_req_i=0; in DRAIN this return takes priority over entering HALTED.
REQ-020 hold SHALL be (state≠RUN) OR data_hazard; hold is evaluated combinationally.
REQ-021 With mem_redirect_i=1 (highest priority), outputs SHALL be pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
REQ-022 Otherwise, with hold=1, outputs SHALL be pc_write=0, if_id_write=0, id_ex_flush=1, and the other flushes 0.
REQ-023 Otherwise, outputs SHALL be pc_write=1, if_id_write=1, and all flushes 0.
REQ-024 Slot update each cycle: WB<=MEM; MEM<=EX, invalidated if mem_redirect_i; EX<={id_valid_i AND id_reg_write_i, id_dest_i}, invalidated if mem_redirect_i or hold.
REQ-025 stall_count SHALL increment by 1 in each cycle with data_hazard=1, state=RUN and mem_redirect_i=0, saturating at all-ones.
REQ-026 flush_count SHALL increment by 1 in each cycle with mem_redirect_i=1, saturating at all-ones.
REQ-027 halt_ack_o SHALL be 1 exactly when state=HALTED (registered).
REQ-028 A redirect in DRAIN or HALTED SHALL still apply REQ-021 and SHALL not change the state.

Reset
REQ-029 While reset=0, SHALL asynchronously force: state RUN, all slots invalid with dest 0, both counters 0, halt_ack_o=0.
REQ-030 After reset release with no inputs active, outputs SHALL be pc_write=1, if_id_write=1, all flushes 0; reset mid-DRAIN SHALL abandon the drain with no residual hold.

Verification
REQ-031 Assert reset=0 for 2 cycles, then release -> pc_write=1, if_id_write=1, flushes 0, counters 0, halt_ack=0.
REQ-032 Cycle 0: ID writes $3; cycle 1: ID reads rs=3 -> hold in cycles 1, 2, 3; issue in cycle 4; stall_count=3, EX slot invalid in cycles 2-4.
REQ-033 Producer with dest $0 followed by a consumer of rs=0 -> no stall; stall_count remains 0.
REQ-034 mem_redirect_i=1 during a data-hazard stall -> all three flushes 1 and pc_write=1; next cycle EX and MEM slots invalid; stall_count unchanged that cycle; flush_count +1.
REQ-035 halt_req=1 with 2 valid slots -> DRAIN for 2 cycles, then halt_ack=1 with pc_write=0; drop halt_req -> RUN next cycle, held ID instruction issues.
REQ-036 Drive stall_count to all-ones via a forced hazard -> the count holds at all-ones; then assert reset=0 in DRAIN -> state RUN and counters 0 immediately.
